// File: rtl/polylut_elastic_reg.sv
// Elastic pipeline stage: two-entry (main + skid) registered buffer or a
// combinational bypass, plus a saturating counter of downstream stall cycles.
module polylut_elastic_reg #(
  parameter int unsigned DataWidth   = 1568,
  parameter int unsigned REG_MODE    = 1,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [DataWidth-1:0]   data_in,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DataWidth-1:0]   data_out,
  input  logic                   flush,
  output logic [STALL_CNT_W-1:0] stall_cnt
);

  logic                   w_stall;
  logic [STALL_CNT_W-1:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != '1)) begin
      r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
    end
  end

  assign stall_cnt = r_stall_cnt;

  if (REG_MODE != 0) begin : g_reg
    typedef enum logic [1:0] {
      ST_EMPTY,
      ST_ONE,
      ST_FULL
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [DataWidth-1:0] r_main;
    logic [DataWidth-1:0] r_skid;
    logic [DataWidth-1:0] w_main_nxt;
    logic [DataWidth-1:0] w_skid_nxt;
    logic                 r_in_ready;
    logic                 r_out_valid;
    logic                 w_in_xfer;
    logic                 w_out_xfer;

    always_comb begin
      w_in_xfer   = in_valid & r_in_ready;
      w_out_xfer  = r_out_valid & out_ready;
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      case (r_state)
        ST_EMPTY: begin
          if (w_in_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = data_in;
          end
        end
        ST_ONE: begin
          if (w_in_xfer && w_out_xfer) begin
            w_main_nxt = data_in;
          end else if (w_in_xfer) begin
            w_state_nxt = ST_FULL;
            w_skid_nxt  = data_in;
          end else if (w_out_xfer) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_xfer) begin
            w_state_nxt = ST_ONE;
            w_main_nxt  = r_skid;
          end
        end
        default: w_state_nxt = ST_EMPTY;
      endcase
      // Flush only needs to empty the state; payload registers are don't-care.
      if (flush) begin
        w_state_nxt = ST_EMPTY;
      end
    end

    // Handshake flags are registered from the next state so neither output
    // has a combinational path from out_ready.
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_state     <= ST_EMPTY;
        r_main      <= '0;
        r_skid      <= '0;
        r_in_ready  <= 1'b0;
        r_out_valid <= 1'b0;
      end else begin
        r_state     <= w_state_nxt;
        r_main      <= w_main_nxt;
        r_skid      <= w_skid_nxt;
        r_in_ready  <= (w_state_nxt != ST_FULL);
        r_out_valid <= (w_state_nxt != ST_EMPTY);
      end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign data_out  = r_main;
    assign w_stall   = r_out_valid & ~out_ready & ~flush;
  end else begin : g_byp
    assign out_valid = in_valid & ~flush;
    assign in_ready  = out_ready & ~flush;
    assign data_out  = data_in;
    assign w_stall   = out_valid & ~out_ready;
  end

endmodule

// File: tb/tb_polylut_elastic_reg.sv
// Bench for polylut_elastic_reg: queue-based reference model checked every
// cycle, plus directed scenarios with literal expectations.
module tb_polylut_elastic_reg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // registered stage (16-bit counter) and a twin with a 4-bit counter
  logic        in_valid, in_ready, out_valid, out_ready, flush;
  logic [7:0]  data_in, data_out;
  logic [15:0] stall_cnt;
  logic        s_in_ready, s_out_valid;
  logic [7:0]  s_data_out;
  logic [3:0]  s_stall;
  // bypass stage
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_flush;
  logic [7:0]  b_din, b_dout;
  logic [15:0] b_stall;

  polylut_elastic_reg #(.DataWidth(8), .REG_MODE(1), .STALL_CNT_W(16)) u_reg (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .flush(flush), .stall_cnt(stall_cnt));

  polylut_elastic_reg #(.DataWidth(8), .REG_MODE(1), .STALL_CNT_W(4)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
    .data_in(data_in), .out_valid(s_out_valid), .out_ready(out_ready),
    .data_out(s_data_out), .flush(flush), .stall_cnt(s_stall));

  polylut_elastic_reg #(.DataWidth(8), .REG_MODE(0), .STALL_CNT_W(16)) u_byp (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .data_in(b_din), .out_valid(b_out_valid), .out_ready(b_out_ready),
    .data_out(b_dout), .flush(b_flush), .stall_cnt(b_stall));

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of at most two accepted payloads.
  logic [7:0] m_q[$];
  logic [7:0] obs[$];
  bit         m_inrdy = 1'b0;
  bit         m_zero  = 1'b1;
  bit         m_live  = 1'b0;
  bit         m_ix, m_ox;
  int         m_stall = 0;
  int         mb_stall = 0;

  always @(posedge clk) begin
    if (!rst) begin
      m_q.delete();
      m_inrdy  = 1'b0;
      m_zero   = 1'b1;
      m_stall  = 0;
      mb_stall = 0;
      m_live   = 1'b1;
    end else begin
      if (b_in_valid && !b_flush && !b_out_ready) mb_stall++;
      if (flush) begin
        m_q.delete();
        m_inrdy = 1'b1;
        m_zero  = 1'b0;
      end else begin
        m_ix = in_valid && m_inrdy;
        m_ox = (m_q.size() != 0) && out_ready;
        if ((m_q.size() != 0) && !out_ready) m_stall++;
        if (m_ox) void'(m_q.pop_front());
        if (m_ix) begin
          m_q.push_back(data_in);
          m_zero = 1'b0;
        end
        m_inrdy = (m_q.size() < 2);
      end
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      chk("in_ready", in_ready, m_inrdy);
      chk("out_valid", out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("data_out", data_out, m_q[0]);
      else if (m_zero)     chk("data_out_zero", data_out, 0);
      chk("stall_cnt", stall_cnt, m_stall);
      chk("sat_out_valid", s_out_valid, m_q.size() != 0);
      if (m_q.size() != 0) chk("sat_data_out", s_data_out, m_q[0]);
      chk("sat_stall_cnt", s_stall, (m_stall > 15) ? 15 : m_stall);
      chk("byp_out_valid", b_out_valid, b_in_valid & ~b_flush);
      chk("byp_in_ready", b_in_ready, b_out_ready & ~b_flush);
      chk("byp_data_out", b_dout, b_din);
      chk("byp_stall_cnt", b_stall, mb_stall);
      if (rst && !flush && out_valid && out_ready) obs.push_back(data_out);
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    cyc(); cyc();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_stall", stall_cnt, 0);
    rst = 1'b1;
    cyc();
    chk("rst_rel_in_ready", in_ready, 1);
    chk("rst_rel_out_valid", out_valid, 0);
    chk("rst_rel_data_out", data_out, 0);
  endtask

  logic pat [8];

  initial begin
    in_valid = 1'b0; data_in = '0; out_ready = 1'b0; flush = 1'b0;
    b_in_valid = 1'b0; b_din = '0; b_out_ready = 1'b0; b_flush = 1'b0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    do_reset();

    // streaming 0x01..0x10 with out_ready held high
    obs.delete();
    out_ready = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_valid = 1'b1; data_in = 8'(i);
      cyc();
      if (i == 1) begin
        chk("stream_lat_valid", out_valid, 1);
        chk("stream_lat_data", data_out, 8'h01);
      end
      chk("stream_in_ready", in_ready, 1);
    end
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("stream_count", obs.size(), 16);
    for (int i = 0; i < 16; i++) chk("stream_order", obs[i], i + 1);
    chk("stream_stall", stall_cnt, 0);

    // backpressure: A1, A2 accepted, A3 held off until space frees up
    obs.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'hA1; cyc();
    data_in = 8'hA2; cyc();
    chk("bp_full_in_ready", in_ready, 0);
    chk("bp_hold_a1", data_out, 8'hA1);
    data_in = 8'hA3; cyc();
    chk("bp_full_in_ready2", in_ready, 0);
    chk("bp_hold_a1_2", data_out, 8'hA1);
    out_ready = 1'b1;
    cyc(); cyc();
    in_valid = 1'b0;
    repeat (3) cyc();
    chk("bp_count", obs.size(), 3);
    chk("bp_out0", obs[0], 8'hA1);
    chk("bp_out1", obs[1], 8'hA2);
    chk("bp_out2", obs[2], 8'hA3);
    chk("bp_stall", stall_cnt, 2);

    // flush while FULL, with a competing input offer
    obs.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'h11; cyc();
    data_in = 8'h22; cyc();
    chk("fl_pre_full", in_ready, 0);
    flush = 1'b1; data_in = 8'h33; cyc();
    flush = 1'b0; in_valid = 1'b0;
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    chk("fl_stall_kept", stall_cnt, 3);
    out_ready = 1'b1;
    repeat (4) cyc();
    chk("fl_nothing_out", obs.size(), 0);
    chk("fl_stall_kept2", stall_cnt, 3);

    // stall counter saturation on the 4-bit twin
    do_reset();
    in_valid = 1'b1; data_in = 8'h77; out_ready = 1'b0; cyc();
    in_valid = 1'b0;
    repeat (14) cyc();
    chk("sat_14", s_stall, 14);
    cyc();
    chk("sat_15", s_stall, 15);
    repeat (5) cyc();
    chk("sat_hold", s_stall, 15);
    chk("sat_wide_20", stall_cnt, 20);
    out_ready = 1'b1;
    repeat (2) cyc();

    // reset while FULL, then 0x5A must be the first output
    obs.delete();
    out_ready = 1'b0;
    in_valid = 1'b1; data_in = 8'h61; cyc();
    data_in = 8'h62; cyc();
    rst = 1'b0; data_in = 8'h63; cyc();
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_data_out", data_out, 0);
    chk("mrst_stall", stall_cnt, 0);
    chk("mrst_in_ready", in_ready, 0);
    rst = 1'b1; data_in = 8'h5A; out_ready = 1'b1;
    cyc();
    chk("mrst_rel_in_ready", in_ready, 1);
    chk("mrst_rel_out_valid", out_valid, 0);
    cyc();
    in_valid = 1'b0;
    chk("mrst_first_valid", out_valid, 1);
    chk("mrst_first_data", data_out, 8'h5A);
    repeat (3) cyc();
    chk("mrst_count", obs.size(), 1);
    chk("mrst_out0", obs[0], 8'h5A);

    // bypass instance with toggling out_ready, then a flush
    b_in_valid = 1'b1; b_din = 8'hC3;
    for (int i = 0; i < 8; i++) begin
      b_out_ready = pat[i];
      #1;
      chk("byp_lit_valid", b_out_valid, 1);
      chk("byp_lit_data", b_dout, 8'hC3);
      chk("byp_lit_ready", b_in_ready, pat[i]);
      cyc();
    end
    chk("byp_lit_stall", b_stall, 4);
    b_flush = 1'b1; b_out_ready = 1'b1;
    #1;
    chk("byp_flush_valid", b_out_valid, 0);
    chk("byp_flush_ready", b_in_ready, 0);
    b_out_ready = 1'b0;
    cyc();
    b_flush = 1'b0; b_in_valid = 1'b0;
    chk("byp_flush_stall", b_stall, 4);
    repeat (2) cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
